axis_ingress: RTL and testbench

//   Receive-side AXI-Stream front end: accepts frames from the MAC/source,

---
 rtl/axis_pkg.sv | 12 +
 rtl/axis_skid_buffer.sv | 97 +++++++++
 rtl/axis_ingress.sv | 144 ++++++++++++++
 tb/tb_axis_ingress.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream ingress/egress blocks.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IN_FRAME,
    DROP
  } ingress_state_e;

  localparam int unsigned TUSER_ERR_BIT = 0;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: full throughput with a registered s_tready.
module axis_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser
);

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  main_last_q, main_last_d;
  logic [USER_WIDTH-1:0] main_user_q, main_user_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic [USER_WIDTH-1:0] skid_user_q, skid_user_d;
  logic                  ready_q, ready_d;
  logic                  accept;

  assign accept = s_tvalid & ready_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_last_d  = main_last_q;
    main_user_d  = main_user_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_user_d  = skid_user_q;
    if (!main_valid_q || m_tready) begin
      // Main slot is free or draining: refill from skid first to keep order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        main_user_d  = skid_user_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = s_tdata;
          main_last_d = s_tlast;
          main_user_d = s_tuser;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_tdata;
      skid_last_d  = s_tlast;
      skid_user_d  = s_tuser;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      main_user_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_user_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      main_user_q  <= main_user_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_user_q  <= skid_user_d;
      ready_q      <= ready_d;
    end
  end

  assign s_tready = ready_q;
  assign m_tvalid = main_valid_q;
  assign m_tdata  = main_data_q;
  assign m_tlast  = main_last_q;
  assign m_tuser  = main_user_q;

endmodule

// File: rtl/axis_ingress.sv
// Receive-side AXI-Stream front end: skid buffering, beat counting, oversize truncation.
// Optional frame statistics counters are enabled by defining AXIS_INGRESS_STATS_EN.
module axis_ingress
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned MAX_FRAME_BEATS = 1518
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [DATA_WIDTH-1:0]                  s_tdata,
  input  logic                                   s_tvalid,
  output logic                                   s_tready,
  input  logic                                   s_tlast,
  input  logic [USER_WIDTH-1:0]                  s_tuser,
  output logic [DATA_WIDTH-1:0]                  m_tdata,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic                                   m_tlast,
  output logic [USER_WIDTH-1:0]                  m_tuser,
  output logic                                   frame_done,
  output logic [$clog2(MAX_FRAME_BEATS+1)-1:0]   frame_beats,
  output logic                                   frame_trunc
`ifdef AXIS_INGRESS_STATS_EN
  ,
  output logic [31:0]                            stat_frames,
  output logic [31:0]                            stat_trunc
`endif
);

  localparam int unsigned CntW = $clog2(MAX_FRAME_BEATS + 1);

  ingress_state_e        state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  frame_done_q, frame_done_d;
  logic [CntW-1:0]       frame_beats_q, frame_beats_d;
  logic                  frame_trunc_q, frame_trunc_d;

  logic                  buf_ready;
  logic                  buf_valid;
  logic                  buf_last;
  logic [USER_WIDTH-1:0] buf_user;
  logic                  accept;
  logic                  at_limit;
  logic                  trunc_beat;

  // While dropping, the tail of the frame is swallowed without touching the buffer.
  assign s_tready   = (state_q == DROP) | buf_ready;
  assign accept     = s_tvalid & s_tready;
  assign at_limit   = (count_q == CntW'(MAX_FRAME_BEATS - 1));
  assign trunc_beat = (state_q != DROP) & at_limit & !s_tlast;
  assign buf_valid  = s_tvalid & (state_q != DROP);
  assign buf_last   = s_tlast | trunc_beat;

  always_comb begin
    buf_user                = s_tuser;
    buf_user[TUSER_ERR_BIT] = s_tuser[TUSER_ERR_BIT] | trunc_beat;
  end

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (buf_valid),
    .s_tready (buf_ready),
    .s_tlast  (buf_last),
    .s_tuser  (buf_user),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    frame_done_d  = 1'b0;
    frame_beats_d = frame_beats_q;
    frame_trunc_d = frame_trunc_q;
    unique case (state_q)
      IDLE, IN_FRAME: begin
        if (accept) begin
          if (s_tlast || at_limit) begin
            frame_done_d  = 1'b1;
            frame_beats_d = count_q + CntW'(1);
            frame_trunc_d = !s_tlast;
            count_d       = '0;
            state_d       = s_tlast ? IDLE : DROP;
          end else begin
            count_d = count_q + CntW'(1);
            state_d = IN_FRAME;
          end
        end
      end
      DROP: begin
        if (accept && s_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_beats_q <= '0;
      frame_trunc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      frame_done_q  <= frame_done_d;
      frame_beats_q <= frame_beats_d;
      frame_trunc_q <= frame_trunc_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_beats = frame_beats_q;
  assign frame_trunc = frame_trunc_q;

`ifdef AXIS_INGRESS_STATS_EN
  logic [31:0] stat_frames_q, stat_trunc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q <= '0;
      stat_trunc_q  <= '0;
    end else if (frame_done_q) begin
      stat_frames_q <= stat_frames_q + 32'd1;
      if (frame_trunc_q) stat_trunc_q <= stat_trunc_q + 32'd1;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_trunc  = stat_trunc_q;
`endif

endmodule

// File: tb/tb_axis_ingress.sv
// Scoreboard bench for axis_ingress with MAX_FRAME_BEATS=8 and a 2-bit tuser.
module tb_axis_ingress;

  localparam int DW   = 8;
  localparam int UW   = 2;
  localparam int MAXB = 8;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic          frame_done;
  logic [CW-1:0] frame_beats;
  logic          frame_trunc;
`ifdef AXIS_INGRESS_STATS_EN
  logic [31:0]   stat_frames;
  logic [31:0]   stat_trunc;
`endif

  always #5 clk = ~clk;

  axis_ingress #(
    .DATA_WIDTH      (DW),
    .USER_WIDTH      (UW),
    .MAX_FRAME_BEATS (MAXB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .frame_done  (frame_done),
    .frame_beats (frame_beats),
    .frame_trunc (frame_trunc)
`ifdef AXIS_INGRESS_STATS_EN
    ,
    .stat_frames (stat_frames),
    .stat_trunc  (stat_trunc)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Expected beats packed as {tlast, tuser, tdata}; status as {trunc, beats}.
  logic [DW+UW:0] beat_q[$];
  logic [CW:0]    stat_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [CW:0] st(input logic trunc, input int beats);
    return {trunc, CW'(beats)};
  endfunction

  // Monitor: pops expectations on every downstream handshake and frame_done pulse.
  initial begin
    logic           prev_stall;
    logic [DW+UW:0] prev_beat;
    logic [DW+UW:0] cur;
    logic [DW+UW:0] eb;
    logic [CW:0]    es;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = {m_tlast, m_tuser, m_tdata};
        if (prev_stall) begin
          check("stall_valid", 32'(m_tvalid), 32'd1);
          check("stall_hold", 32'(cur), 32'(prev_beat));
        end
        if (m_tvalid && m_tready) begin
          if (beat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got=%0h exp=none", cur);
          end else begin
            eb = beat_q.pop_front();
            check("beat", 32'(cur), 32'(eb));
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = cur;
        if (frame_done) begin
          if (stat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame_done: got=%0h exp=none", {frame_trunc, frame_beats});
          end else begin
            es = stat_q.pop_front();
            check("frame_status", 32'({frame_trunc, frame_beats}), 32'(es));
          end
        end
      end
    end
  end

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
    s_tdata  = '0;
  endtask

  // Present one beat, wait (bounded) for acceptance, push its expected output if forwarded.
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [UW-1:0] u,
                           input logic fwd, input logic el, input logic [UW-1:0] eu,
                           input logic must_ready);
    int   n;
    logic done;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    n        = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (must_ready && n == 0) check("drop_ready", 32'(s_tready), 32'd1);
      if (s_tready) begin
        done = 1'b1;
        if (fwd) beat_q.push_back({el, eu, d});
      end else begin
        n++;
        if (n > 50) begin
          total++;
          bad++;
          $display("FAIL accept_timeout: got=stalled exp=accept data=%0h", d);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((beat_q.size() != 0 || stat_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    m_tready = 1'b0;
    idle();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_m_tuser", 32'(m_tuser), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_beats", 32'(frame_beats), 32'd0);
    check("rst_frame_trunc", 32'(frame_trunc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("tready_before_edge", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    check("tready_after_edge", 32'(s_tready), 32'd1);
    m_tready = 1'b1;

    // 4-beat frame, upper tuser bit and error bit pass through
    stat_q.push_back(st(1'b0, 4));
    send_beat(8'hA1, 1'b0, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0);
    s_tvalid = 1'b0;
    @(negedge clk);
    check("latency_valid", 32'(m_tvalid), 32'd1);
    check("latency_data", 32'(m_tdata), 32'hA1);
    @(posedge clk);
    #1;
    send_beat(8'hA2, 1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
    send_beat(8'hA3, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    send_beat(8'hA4, 1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0);
    idle();
    repeat (5) @(posedge clk);
    #1;
    check("beats_held", 32'(frame_beats), 32'd4);
    check("trunc_held", 32'(frame_trunc), 32'd0);

    // Backpressure mid-frame for 3 cycles
    stat_q.push_back(st(1'b0, 6));
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_beat(8'(8'h50 + i), (i == 5), 2'b00, 1'b1, (i == 5), 2'b00, 1'b0);
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        m_tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stall_tready_low", 32'(s_tready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();

    // 12-beat frame truncated at 8; skid full when DROP starts
    stat_q.push_back(st(1'b1, 8));
    for (int i = 0; i < 7; i++)
      send_beat(8'(8'h10 + i), 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    m_tready = 1'b0;
    send_beat(8'h17, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0);
    for (int i = 8; i < 12; i++)
      send_beat(8'(8'h10 + i), (i == 11), 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
    idle();
    m_tready = 1'b1;
    drain();

    // Exactly-max frame followed by a 1-beat frame
    stat_q.push_back(st(1'b0, 8));
    stat_q.push_back(st(1'b0, 1));
    for (int i = 0; i < 8; i++)
      send_beat(8'(8'h30 + i), (i == 7), 2'b00, 1'b1, (i == 7), 2'b00, 1'b0);
    send_beat(8'h40, 1'b1, 2'b11, 1'b1, 1'b1, 2'b11, 1'b0);
    idle();
    drain();

    // Reset mid-frame with beats held in the buffer
    send_beat(8'h60, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    send_beat(8'h61, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    m_tready = 1'b0;
    send_beat(8'h62, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_m_tdata", 32'(m_tdata), 32'd0);
    check("midrst_s_tready", 32'(s_tready), 32'd0);
    beat_q.delete();
    stat_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    m_tready = 1'b1;
    stat_q.push_back(st(1'b0, 2));
    send_beat(8'h70, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    send_beat(8'h71, 1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0);
    idle();
    drain();

    check("drain_beats", 32'(beat_q.size()), 32'd0);
    check("drain_status", 32'(stat_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
